// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order imem reads, buffers words in a prefetch FIFO, flushes on redirect.
// Optional macro FETCH_PERF_EN adds perf_fetched/perf_flushed saturating counters.
module fetch_unit #(
  parameter int              PC_W       = 8,
  parameter int              INSTR_W    = 16,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] PC_STEP    = PC_W'(1)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_flushed
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic               r_run;
  logic [PC_W-1:0]    r_fetch_pc;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   r_discard;
  entry_t             r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [PC_W-1:0]    r_tag [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_tag_wr;
  logic [PTR_W-1:0]   r_tag_rd;

  logic [CNT_W:0]     w_occ;
  logic               w_req;
  logic               w_issue;
  logic               w_pop;
  logic               w_drop;
  logic               w_push;
  logic [CNT_W-1:0]   w_out_next;

  // Outstanding requests reserve FIFO slots, so a response can never find the FIFO full.
  assign w_occ      = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req      = r_run & ~redirect & (w_occ < DEPTH_C);
  assign w_issue    = w_req & imem_ready;
  assign w_pop      = (r_count != '0) & out_ready;
  assign w_drop     = imem_rvalid & (redirect | (r_discard != '0));
  assign w_push     = imem_rvalid & ~w_drop;
  assign w_out_next = r_outstanding + CNT_W'(w_issue) - CNT_W'(imem_rvalid);

  assign imem_req   = w_req;
  assign imem_addr  = r_fetch_pc;
  assign out_valid  = (r_count != '0);
  assign out_instr  = r_fifo[r_rd_ptr].instr;
  assign out_pc     = r_fifo[r_rd_ptr].pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run         <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= w_out_next;
      if (redirect) begin
        // Everything still in flight after this cycle is stale.
        r_fetch_pc <= redirect_pc;
        r_discard  <= w_out_next;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_tag_wr   <= '0;
        r_tag_rd   <= '0;
      end else begin
        if (w_issue) begin
          r_fetch_pc      <= r_fetch_pc + PC_STEP;
          r_tag[r_tag_wr] <= r_fetch_pc;
          r_tag_wr        <= r_tag_wr + PTR_W'(1);
        end
        if (imem_rvalid && (r_discard != '0)) begin
          r_discard <= r_discard - CNT_W'(1);
        end
        if (w_push) begin
          r_fifo[r_wr_ptr] <= '{pc: r_tag[r_tag_rd], instr: imem_rdata};
          r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
          r_tag_rd         <= r_tag_rd + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0]    r_perf_fetched;
  logic [15:0]    r_perf_flushed;
  logic [CNT_W:0] w_flush_add;
  logic [16:0]    w_flush_sum;

  // Lost work: entries left in the FIFO plus any response dropped in the redirect cycle,
  // then one per stale response that arrives later.
  assign w_flush_add = redirect
                     ? ({1'b0, r_count} - (CNT_W + 1)'(w_pop) + (CNT_W + 1)'(imem_rvalid))
                     : (CNT_W + 1)'(imem_rvalid & (r_discard != '0));
  assign w_flush_sum = {1'b0, r_perf_flushed} + 17'(w_flush_add);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      if (w_pop && (r_perf_fetched != 16'hFFFF)) begin
        r_perf_fetched <= r_perf_fetched + 16'd1;
      end
      r_perf_flushed <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    w_push |-> (r_count != FULL_C));
  a_no_orphan: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with configurable latency plus handshake/issue logs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        redirect;
  logic [7:0]  redirect_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_flushed;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;
  logic mem_flush = 1'b1;

  logic [7:0]  mq_addr[$];
  int          mq_due[$];
  logic [7:0]  iss_log[$];
  logic [7:0]  hs_pc[$];
  logic [15:0] hs_instr[$];

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {~a, a};
  endfunction

  // Memory: a request accepted at edge k returns data sampled at edge k+lat.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (mem_flush) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (mq_due.size() > 0 && mq_due[0] == cyc + 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req && imem_ready) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + 1 + lat);
        iss_log.push_back(imem_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      hs_pc.push_back(out_pc);
      hs_instr.push_back(out_instr);
    end
  end

  task automatic clear_logs();
    iss_log.delete();
    hs_pc.delete();
    hs_instr.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    mem_flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mem_flush = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (out_instr !== 16'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0000", out_instr); end
    n_tests++; if (out_pc !== 8'h0) begin n_fail++; $display("FAIL reset_pc got %h want 00", out_pc); end
`ifdef FETCH_PERF_EN
    n_tests++; if (perf_fetched !== 16'h0) begin n_fail++; $display("FAIL reset_perf_fetched got %h want 0", perf_fetched); end
    n_tests++; if (perf_flushed !== 16'h0) begin n_fail++; $display("FAIL reset_perf_flushed got %h want 0", perf_flushed); end
`endif
  endtask

  task automatic test_stream();
    int bad;
    lat = 1; imem_ready = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    mem_flush = 1'b0;
    clear_logs();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== (i == 3)) begin n_fail++; $display("FAIL stream_first_valid step %0d got %b want %b", i, out_valid, (i == 3)); end
    end
    n_tests++; if (out_pc !== 8'h00 || out_instr !== mem_word(8'h00)) begin
      n_fail++; $display("FAIL stream_first_word got pc %h instr %h want pc 00 instr %h", out_pc, out_instr, mem_word(8'h00)); end
    repeat (20) @(negedge clk);
    n_tests++; if (hs_pc.size() < 3 || iss_log.size() < 3) begin
      n_fail++; $display("FAIL stream_count got hs %0d iss %0d want >=3", hs_pc.size(), iss_log.size()); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (iss_log[i] !== 8'(i)) begin n_fail++; $display("FAIL stream_addr[%0d] got %h want %h", i, iss_log[i], 8'(i)); end
      n_tests++; if (hs_pc[i] !== 8'(i) || hs_instr[i] !== mem_word(8'(i))) begin
        n_fail++; $display("FAIL stream_out[%0d] got pc %h instr %h want pc %h instr %h", i, hs_pc[i], hs_instr[i], 8'(i), mem_word(8'(i))); end
    end
    bad = 0;
    for (int i = 1; i < hs_pc.size(); i++) if (hs_pc[i] !== hs_pc[i-1] + 8'd1) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stream_order got %0d gaps want 0", bad); end
  endtask

  task automatic test_stall();
    int bad;
    lat = 1; imem_ready = 1'b1; out_ready = 1'b0;
    do_reset();
    bad = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n >= 5 && (out_valid !== 1'b1 || out_pc !== 8'h00)) bad++;
    end
    n_tests++; if (iss_log.size() != 2) begin n_fail++; $display("FAIL stall_issued got %0d want 2", iss_log.size()); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req got %b want 0", imem_req); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stall_head_stable got %0d changes want 0", bad); end
    n_tests++; if (out_instr !== mem_word(8'h00)) begin n_fail++; $display("FAIL stall_head_instr got %h want %h", out_instr, mem_word(8'h00)); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (15) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (hs_pc[i] !== 8'(i) || hs_instr[i] !== mem_word(8'(i))) begin
        n_fail++; $display("FAIL stall_release[%0d] got pc %h instr %h want pc %h", i, hs_pc[i], hs_instr[i], 8'(i)); end
    end
    bad = 0;
    for (int i = 1; i < hs_pc.size(); i++) if (hs_pc[i] !== hs_pc[i-1] + 8'd1) bad++;
    n_tests++; if (bad != 0 || hs_pc.size() < 3) begin n_fail++; $display("FAIL stall_order got %0d gaps size %0d want 0 gaps", bad, hs_pc.size()); end
  endtask

  task automatic test_redirect();
    lat = 3; imem_ready = 1'b1; out_ready = 1'b1;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (iss_log.size() != 2) begin n_fail++; $display("FAIL redir_outstanding got %0d want 2", iss_log.size()); end
    redirect = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_no_req got %b want 0", imem_req); end
    @(posedge clk); #1;
    redirect = 1'b0;
    repeat (25) @(negedge clk);
    n_tests++; if (hs_pc[0] !== 8'h40 || hs_instr[0] !== mem_word(8'h40)) begin
      n_fail++; $display("FAIL redir_first got pc %h instr %h want pc 40 instr %h", hs_pc[0], hs_instr[0], mem_word(8'h40)); end
    n_tests++; if (hs_pc[1] !== 8'h41 || hs_instr[1] !== mem_word(8'h41)) begin
      n_fail++; $display("FAIL redir_second got pc %h instr %h want pc 41", hs_pc[1], hs_instr[1]); end
    n_tests++; if (iss_log[2] !== 8'h40) begin n_fail++; $display("FAIL redir_restart_addr got %h want 40", iss_log[2]); end
`ifdef FETCH_PERF_EN
    n_tests++; if (perf_flushed !== 16'd2) begin n_fail++; $display("FAIL redir_perf_flushed got %0d want 2", perf_flushed); end
`endif
  endtask

  task automatic test_back_to_back();
    lat = 3; imem_ready = 1'b1; out_ready = 1'b1;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    redirect = 1'b1; redirect_pc = 8'h80;
    @(posedge clk); #1;
    redirect_pc = 8'h90;
    @(posedge clk); #1;
    redirect = 1'b0;
    repeat (25) @(negedge clk);
    n_tests++; if (hs_pc[0] !== 8'h90 || hs_instr[0] !== mem_word(8'h90)) begin
      n_fail++; $display("FAIL b2b_first got pc %h instr %h want pc 90", hs_pc[0], hs_instr[0]); end
    n_tests++; if (hs_pc[1] !== 8'h91) begin n_fail++; $display("FAIL b2b_second got pc %h want 91", hs_pc[1]); end
  endtask

  task automatic test_ready_hold();
    lat = 1; imem_ready = 1'b0; out_ready = 1'b1;
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
        n_fail++; $display("FAIL hold_step%0d got req %b addr %h want req 1 addr 00", i, imem_req, imem_addr); end
      @(posedge clk); #1;
    end
    n_tests++; if (iss_log.size() != 0) begin n_fail++; $display("FAIL hold_no_issue got %0d want 0", iss_log.size()); end
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
      n_fail++; $display("FAIL hold_advance got req %b addr %h want req 1 addr 01", imem_req, imem_addr); end
    n_tests++; if (iss_log.size() != 1) begin n_fail++; $display("FAIL hold_one_issue got %0d want 1", iss_log.size()); end
    imem_ready = 1'b1;
  endtask

  task automatic test_wrap();
    lat = 1; imem_ready = 1'b1; out_ready = 1'b1;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    redirect = 1'b1; redirect_pc = 8'hFE;
    @(posedge clk); #1;
    redirect = 1'b0;
    clear_logs();
    repeat (30) @(negedge clk);
    n_tests++; if (iss_log[0] !== 8'hFE || iss_log[1] !== 8'hFF || iss_log[2] !== 8'h00) begin
      n_fail++; $display("FAIL wrap_addr got %h %h %h want fe ff 00", iss_log[0], iss_log[1], iss_log[2]); end
    n_tests++; if (hs_pc[0] !== 8'hFE || hs_pc[1] !== 8'hFF || hs_pc[2] !== 8'h00) begin
      n_fail++; $display("FAIL wrap_out got %h %h %h want fe ff 00", hs_pc[0], hs_pc[1], hs_pc[2]); end
    n_tests++; if (hs_instr[2] !== mem_word(8'h00)) begin n_fail++; $display("FAIL wrap_instr got %h want %h", hs_instr[2], mem_word(8'h00)); end
  endtask

  task automatic test_midreset();
    lat = 2; imem_ready = 1'b1; out_ready = 1'b1;
    do_reset();
    repeat (12) @(posedge clk);
    #1;
    n_tests++; if (hs_pc.size() < 3) begin n_fail++; $display("FAIL mid_streaming got %0d want >=3", hs_pc.size()); end
    rst = 1'b0;
    mem_flush = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", out_valid); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req got %b want 0", imem_req); end
`ifdef FETCH_PERF_EN
    n_tests++; if (perf_fetched !== 16'h0 || perf_flushed !== 16'h0) begin
      n_fail++; $display("FAIL mid_perf got %h %h want 0 0", perf_fetched, perf_flushed); end
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    mem_flush = 1'b0;
    clear_logs();
    repeat (12) @(negedge clk);
    n_tests++; if (iss_log[0] !== 8'h00) begin n_fail++; $display("FAIL mid_restart_addr got %h want 00", iss_log[0]); end
    n_tests++; if (hs_pc[0] !== 8'h00 || hs_instr[0] !== mem_word(8'h00)) begin
      n_fail++; $display("FAIL mid_restart_out got pc %h instr %h want pc 00", hs_pc[0], hs_instr[0]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; imem_ready = 1'b0; out_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 8'h00;
    repeat (3) @(posedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_ready_hold();
    test_wrap();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
